mnd_issue: RTL and testbench

- E-stage controller that drives the multiply/divide unit.
- Decodes the md-class op in E and issues start, type and HI/LO write requests to the unit.
- Keeps its own busy model, so D is stalled in the same cycle a start issues, before the unit's busy output rises.
- Selects HI/LO for mfhi/mflo and cross-checks its busy model against the unit.

---
 rtl/mnd_issue.sv | 140 ++++++++++++++
 tb/tb_mnd_issue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mnd_issue.sv
// ==== mnd_issue : E-stage issue/stall controller for the mult/div unit (rev 1.0) ====
`default_nettype none

module mnd_issue #(
  parameter int MULT_BUSY = 6,
  parameter int DIV_BUSY  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  d_mdOp,
  input  logic [3:0]  e_mdOp,
  input  logic        e_valid,
  input  logic        requestInt,
  input  logic        mnd_busy,
  input  logic [31:0] mnd_HI,
  input  logic [31:0] mnd_LO,
  output logic        start,
  output logic [3:0]  MNDType,
  output logic [1:0]  MNDWE,
  output logic        stall_D,
  output logic [31:0] md_rdata,
  output logic        sync_err
);

  localparam logic [3:0] c_MNDTYPEDEFAULT = 4'd0;
  localparam logic [3:0] c_MNDMULT        = 4'd1;
  localparam logic [3:0] c_MNDMULTU       = 4'd2;
  localparam logic [3:0] c_MNDDIV         = 4'd3;
  localparam logic [3:0] c_MNDDIVU        = 4'd4;
  localparam logic [1:0] c_MNDWRITEHI     = 2'b01;
  localparam logic [1:0] c_MNDWRITELO     = 2'b10;

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MFHI  = 4'd5;
  localparam logic [3:0] c_OP_MFLO  = 4'd6;
  localparam logic [3:0] c_OP_MTHI  = 4'd7;
  localparam logic [3:0] c_OP_MTLO  = 4'd8;

  localparam int c_CNT_W = $clog2(((MULT_BUSY > DIV_BUSY) ? MULT_BUSY : DIV_BUSY) + 1);
  localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_BUSY);
  localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_BUSY);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_sync_err;

  logic w_issue_ok;
  logic w_idle;
  logic w_e_start_op;
  logic w_e_md;
  logic w_d_md;
  logic w_e_is_mult;
  logic w_busy_model;

  assign w_issue_ok   = e_valid && !requestInt;
  assign w_idle       = (r_state == S_IDLE);
  assign w_e_start_op = (e_mdOp >= c_OP_MULT) && (e_mdOp <= c_OP_DIVU);
  assign w_e_md       = (e_mdOp >= c_OP_MULT) && (e_mdOp <= c_OP_MTLO);
  assign w_d_md       = (d_mdOp >= c_OP_MULT) && (d_mdOp <= c_OP_MTLO);
  assign w_e_is_mult  = (e_mdOp == c_OP_MULT) || (e_mdOp == c_OP_MULTU);

  always_comb begin
    start    = w_issue_ok && w_e_start_op && w_idle;
    MNDType  = c_MNDTYPEDEFAULT;
    MNDWE    = 2'b00;
    md_rdata = 32'd0;
    if (w_issue_ok) begin
      case (e_mdOp)
        c_OP_MULT:  MNDType = c_MNDMULT;
        c_OP_MULTU: MNDType = c_MNDMULTU;
        c_OP_DIV:   MNDType = c_MNDDIV;
        c_OP_DIVU:  MNDType = c_MNDDIVU;
        default:    MNDType = c_MNDTYPEDEFAULT;
      endcase
      if (w_idle && (e_mdOp == c_OP_MTHI)) MNDWE = c_MNDWRITEHI;
      if (w_idle && (e_mdOp == c_OP_MTLO)) MNDWE = c_MNDWRITELO;
    end
    if (e_mdOp == c_OP_MFHI) md_rdata = mnd_HI;
    if (e_mdOp == c_OP_MFLO) md_rdata = mnd_LO;
  end

  // The start cycle already counts as busy so D stalls before the unit reacts.
  assign w_busy_model = !w_idle || start;
  assign stall_D      = (w_d_md && w_busy_model) || (e_valid && w_e_md && !w_idle);
  assign sync_err     = r_sync_err;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_e_is_mult ? c_MULT_LOAD : c_DIV_LOAD;
        end
      end
      S_BUSY: begin
        // The unit freezes while an interrupt is taken; mirror that.
        if (!requestInt) begin
          if (r_cnt <= c_CNT_ONE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - c_CNT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sync_err <= r_sync_err | (mnd_busy != (r_state == S_BUSY));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mnd_issue.sv
// ==== tb_mnd_issue : randomized + directed bench for mnd_issue (rev 1.0) ====
`default_nettype none

module tb_mnd_issue;

  localparam logic [3:0] T_DEFAULT = 4'd0;
  localparam logic [3:0] T_MULT    = 4'd1;
  localparam logic [3:0] T_MULTU   = 4'd2;
  localparam logic [3:0] T_DIV     = 4'd3;
  localparam logic [3:0] T_DIVU    = 4'd4;
  localparam logic [1:0] WE_HI     = 2'b01;
  localparam logic [1:0] WE_LO     = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  d_mdOp = '0;
  logic [3:0]  e_mdOp = '0;
  logic        e_valid = 1'b0;
  logic        requestInt = 1'b0;
  logic        mnd_busy;
  logic [31:0] mnd_HI = '0;
  logic [31:0] mnd_LO = '0;
  logic        start;
  logic [3:0]  MNDType;
  logic [1:0]  MNDWE;
  logic        stall_D;
  logic [31:0] md_rdata;
  logic        sync_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: remaining busy cycles of the unit, and the sticky error it implies.
  int   rem = 0;
  logic exp_err = 1'b0;
  logic force_zero = 1'b0;

  assign mnd_busy = force_zero ? 1'b0 : (rem > 0);

  mnd_issue #(.MULT_BUSY(6), .DIV_BUSY(11)) dut (
    .clk(clk), .reset(reset), .d_mdOp(d_mdOp), .e_mdOp(e_mdOp), .e_valid(e_valid),
    .requestInt(requestInt), .mnd_busy(mnd_busy), .mnd_HI(mnd_HI), .mnd_LO(mnd_LO),
    .start(start), .MNDType(MNDType), .MNDWE(MNDWE), .stall_D(stall_D),
    .md_rdata(md_rdata), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_md(input logic [3:0] op);
    return (op >= 1) && (op <= 8);
  endfunction

  function automatic logic exp_start_f();
    return e_valid && !requestInt && (e_mdOp >= 1) && (e_mdOp <= 4) && (rem == 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem     <= 0;
      exp_err <= 1'b0;
    end else begin
      exp_err <= exp_err | (mnd_busy != (rem > 0));
      if (rem == 0) begin
        if (exp_start_f()) rem <= (e_mdOp <= 2) ? 6 : 11;
      end else if (!requestInt) begin
        rem <= rem - 1;
      end
    end
  end

  always @(negedge clk) begin
    logic        busy, q, es, bm, es_stall;
    logic [1:0]  ewe;
    logic [31:0] erd;
    logic [3:0]  ety;
    busy = (rem > 0);
    q    = e_valid && !requestInt;
    es   = exp_start_f();
    ewe  = (q && !busy && e_mdOp == 8) ? WE_LO :
           (q && !busy && e_mdOp == 7) ? WE_HI : 2'b00;
    bm   = busy || es;
    es_stall = (is_md(d_mdOp) && bm) || (e_valid && is_md(e_mdOp) && busy);
    erd  = (e_mdOp == 5) ? mnd_HI : (e_mdOp == 6) ? mnd_LO : 32'd0;
    case (e_mdOp)
      4'd1: ety = T_MULT;
      4'd2: ety = T_MULTU;
      4'd3: ety = T_DIV;
      4'd4: ety = T_DIVU;
      default: ety = T_DEFAULT;
    endcase
    chk("m_start", start, es);
    chk("m_we", MNDWE, ewe);
    chk("m_stall", stall_D, es_stall);
    chk("m_rdata", md_rdata, erd);
    chk("m_syncerr", sync_err, exp_err);
    if (es) chk("m_type", MNDType, ety);
  end

  int          t_n, t_bad_we;
  logic        t_done, t_st0, t_st_end;
  logic [3:0]  t_ty0;
  logic [1:0]  t_we0, t_we_end;
  logic [31:0] t_rd_end, t_hi;

  // Cycle 0 presents op in E; later cycles present e_after (valid if nonzero).
  // Stops at the first cycle k>0 that is unstalled or issues a new start.
  task automatic run_op(input logic [3:0] op, input logic [3:0] e_after, input logic [3:0] dop,
                        input int irq_from, input int irq_len);
    t_n = 0; t_bad_we = 0; t_done = 1'b0;
    for (int k = 0; k < 100 && !t_done; k++) begin
      @(posedge clk); #1;
      e_valid    = (k == 0) || (e_after != 0);
      e_mdOp     = (k == 0) ? op : e_after;
      d_mdOp     = dop;
      requestInt = (k >= irq_from) && (k < irq_from + irq_len);
      mnd_HI     = $urandom;
      mnd_LO     = $urandom;
      @(negedge clk);
      if (k == 0) begin
        t_st0 = start; t_ty0 = MNDType; t_we0 = MNDWE;
      end
      if (k > 0 && (!stall_D || start)) begin
        t_done = 1'b1; t_st_end = start; t_we_end = MNDWE; t_rd_end = md_rdata; t_hi = mnd_HI;
      end else if (stall_D) begin
        t_n++;
        if (MNDWE != 2'b00) t_bad_we++;
      end
    end
    if (!t_done) chk("run_op_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    e_valid = 1'b0; e_mdOp = '0; d_mdOp = '0; requestInt = 1'b0;
    repeat (14) @(posedge clk);
  endtask

  initial begin
    #23 reset = 1'b1;

    run_op(4'd1, 4'd5, 4'd5, 100, 0);
    chk("mult_start", t_st0, 1'b1);
    chk("mult_type", t_ty0, T_MULT);
    chk("mult_stall_len", t_n, 32'd7);
    chk("mult_mfhi", t_rd_end, t_hi);
    drain();

    run_op(4'd3, 4'd1, 4'd1, 100, 0);
    chk("div_type", t_ty0, T_DIV);
    chk("div_stall_len", t_n, 32'd12);
    chk("div_second_start", t_st_end, 1'b1);
    drain();

    run_op(4'd3, 4'd0, 4'd1, 7, 3);
    chk("irq_freeze_len", t_n, 32'd15);
    chk("irq_freeze_err", sync_err, 1'b0);
    drain();

    run_op(4'd2, 4'd2, 4'd5, 0, 1);
    chk("irq_issue_start", t_st0, 1'b0);
    chk("irq_issue_we", t_we0, 2'b00);
    chk("irq_issue_stall", t_n, 32'd0);
    chk("irq_issue_idle", t_st_end, 1'b1);
    drain();

    run_op(4'd7, 4'd0, 4'd0, 100, 0);
    chk("mthi_we", t_we0, WE_HI);
    chk("mthi_we_once", t_we_end, 2'b00);
    drain();

    run_op(4'd1, 4'd8, 4'd0, 100, 0);
    chk("mtlo_busy_stall", t_n, 32'd6);
    chk("mtlo_busy_we", t_bad_we, 32'd0);
    chk("mtlo_we_after", t_we_end, WE_LO);
    drain();

    // Mismatch injection then asynchronous reset mid-operation.
    @(posedge clk); #1;
    e_valid = 1'b1; e_mdOp = 4'd1;
    @(posedge clk); #1;
    e_valid = 1'b0; e_mdOp = 4'd0; force_zero = 1'b1;
    @(posedge clk); #1;
    force_zero = 1'b0;
    @(negedge clk);
    chk("mismatch_set", sync_err, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("mismatch_sticky", sync_err, 1'b1);
    end
    @(negedge clk); #2;
    reset = 1'b0; e_valid = 1'b1; e_mdOp = 4'd8; d_mdOp = 4'd1;
    #1;
    chk("areset_err", sync_err, 1'b0);
    chk("areset_stall", stall_D, 1'b0);
    chk("areset_idle_we", MNDWE, WE_LO);
    @(negedge clk); #2;
    reset = 1'b1; e_valid = 1'b0; e_mdOp = 4'd0; d_mdOp = 4'd0;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      e_valid    = ($urandom_range(0, 3) != 0);
      e_mdOp     = 4'($urandom_range(0, 15));
      d_mdOp     = 4'($urandom_range(0, 15));
      requestInt = ($urandom_range(0, 7) == 0);
      mnd_HI     = $urandom;
      mnd_LO     = $urandom;
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
